fp_serial_alu: RTL and testbench
================================

FP_SERIAL_ALU -- requirements
Module: fp_serial_alu

Interface
REQ-001 SHALL have parameter BUS_W, default 8: beat width in bits; legal values 8, 16 and 32.
REQ-002 SHALL derive constant BEATS = 32/BUS_W: the number of beats per operand and per result.
REQ-003 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  in  1  request to begin an operation; sampled in IDLE only.
REQ-006 SHALL have port op  in  2  operation code: 0 ADD, 1 SUB, 2 MIN, 3 MAX.
REQ-007 SHALL have port in_data  in  BUS_W  operand beat.
REQ-008 SHALL have port in_valid  in  1  in_data valid.
REQ-009 SHALL have port in_ready  out  1  block accepts an operand beat.
REQ-010 SHALL have port out_data  out  BUS_W  result beat.
REQ-011 SHALL have port out_valid  out  1  out_data valid.
REQ-012 SHALL have port out_ready  in  1  sink accepts a result beat.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port busy  out  1  high in every state except IDLE.
REQ-015 SHALL have port state_out  out  3  current state encoding.

Function
REQ-016 SHALL implement states IDLE=0, LOAD_A=1, LOAD_B=2, EXEC=3 and OUT=4; encodings 5-7 SHALL return to IDLE on the next cycle.
REQ-017 In IDLE, start=1 SHALL latch op, clear the beat counter and move to LOAD_A; start outside IDLE SHALL be ignored.
REQ-018 A beat transfers only in a cycle with valid=1 and ready=1 on the same channel; the counterpart signal SHALL be the only condition gating it.
REQ-019 in_ready SHALL be 1 exactly in LOAD_A and LOAD_B; out_valid SHALL be 1 exactly in OUT.
REQ-020 Beats SHALL be little-endian: beat k occupies bits [k*BUS_W +: BUS_W]; the beat counter SHALL run 0..BEATS-1 and wrap to 0 on each phase change.
REQ-021 An accepted beat at counter BEATS-1 SHALL advance the state: LOAD_A->LOAD_B, LOAD_B->EXEC, OUT->IDLE.
REQ-022 EXEC SHALL last exactly one cycle and register the result, then go to OUT.
REQ-023 ADD/SUB SHALL return fp_addsub(a, b, sub=(op==1)).
REQ-024 MIN/MAX SHALL compare ordered keys, where key = ~x if x[31]=1, else x^32'h80000000 (unsigned). Consequences: -0 < +0; NaN receives no special treatment; ties return a.
REQ-025 out_data SHALL be driven from the result register slice selected by the beat counter, so it is valid in the first OUT cycle.
REQ-026 out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-027 done SHALL be 1 for exactly the cycle after the final result beat is accepted, i.e. the first IDLE cycle.
REQ-028 start=1 in the same cycle as done=1 SHALL be accepted.
REQ-029 Latency with no stalls, start sampled at cycle T: A beats T+1..T+BEATS; B beats T+BEATS+1..T+2*BEATS; EXEC T+2*BEATS+1; OUT T+2*BEATS+2..T+3*BEATS+1; done T+3*BEATS+2.
REQ-030 out_data SHALL read 0 whenever out_valid=0.

Reset
REQ-031 rst=1 at a clock edge SHALL force state IDLE, beat counter 0, operands, result and latched op to 0, and done=0, regardless of current state.
REQ-032 After reset: in_ready=0, out_valid=0, out_data=0, busy=0, state_out=0.
REQ-033 Reset mid-operation SHALL discard all partial data; the next started operation SHALL compute correctly.

Structure
REQ-034 Shared package fp_alu_pkg SHALL hold the op encodings, state encodings and FP_W=32.
REQ-035 SHALL instantiate the existing combinational sub-module fp_addsub (a, b, sub, result); MIN/MAX logic SHALL be local.

Verification
REQ-036 BUS_W=8, ADD: A beats 00 00 80 3F (1.0), B beats 00 00 00 40 (2.0) -> out beats 00 00 40 40 (3.0); done exactly at T+14.
REQ-037 SUB 0x3F800000 - 0x3F800000 -> 0x00000000; MAX 0xBF800000 vs 0x3F000000 -> 0x3F000000; MIN 0x80000000 vs 0x00000000 -> 0x80000000.
REQ-038 Random in_valid gaps, plus out_ready=0 for 3 cycles at result beat 1 -> result unchanged; out_data stable during the stall; done delayed by the total stall count.
REQ-039 rst pulse during LOAD_B beat 2 -> all outputs at reset values next cycle; a following ADD 1.0+2.0 -> 0x40400000.
REQ-040 BUS_W=16 and BUS_W=32 builds, ADD 1.0+2.0 -> 2 and 1 beats respectively, done at T+8 and T+5; start asserted with done -> back-to-back operations with no idle cycle lost.

Source files
------------

// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: shared FP32 width, op and state encodings, and the MIN/MAX ordering key
package fp_alu_pkg;
  localparam int FP_W = 32;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MIN = 2'd2, OP_MAX = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE = 3'd0, LOAD_A = 3'd1, LOAD_B = 3'd2, EXEC = 3'd3, OUT = 3'd4} state_e;
  function automatic logic [FP_W-1:0] key(input logic [FP_W-1:0] x);
    return x[FP_W-1] ? ~x : x ^ 32'h8000_0000;
  endfunction
endpackage

// File: rtl/fp_serial_alu_if.sv
// fp_serial_alu_if: start/op, operand beat stream in, result beat stream out, done/busy/state_out status
interface fp_serial_alu_if #(parameter int BUS_W = 8);
  logic             start;
  logic [1:0]       op;
  logic [BUS_W-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             done;
  logic             busy;
  logic [2:0]       state_out;
  modport master (
    output start, op, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, done, busy, state_out
  );
  modport slave (
    input  start, op, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, done, busy, state_out
  );
endinterface

// File: rtl/fp_addsub.sv
// fp_addsub: combinational IEEE-754 single add/sub, round-to-nearest-even; a, b, sub in, result out
module fp_addsub (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] result
);
  logic [31:0] bn, x, y;
  logic [9:0]  ex, ey, d, sh, en, ef;
  logic [26:0] mx, my, ys, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [24:0] m25;
  logic        rnd;
  always_comb begin
    bn = {b[31] ^ sub, b[30:0]};
    x = (a[30:0] >= bn[30:0]) ? a : bn;
    y = (a[30:0] >= bn[30:0]) ? bn : a;
    ex = {2'b0, x[30:23] | {7'b0, x[30:23] == 8'd0}};
    ey = {2'b0, y[30:23] | {7'b0, y[30:23] == 8'd0}};
    mx = {x[30:23] != 8'd0, x[22:0], 3'b0};
    my = {y[30:23] != 8'd0, y[22:0], 3'b0};
    d = ex - ey;
    ys = (d > 10'd26) ? {26'b0, |my} : (my >> d) | {26'b0, |(my & ~({27{1'b1}} << d))};
    sum = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, ys} : {1'b0, mx} - {1'b0, ys};
    lz = 5'd0;
    for (int i = 0; i < 27; i++) if (sum[i]) lz = 5'(26 - i);
    sh = ({5'b0, lz} < ex - 10'd1) ? {5'b0, lz} : ex - 10'd1;
    norm = sum[27] ? {sum[27:2], |sum[1:0]} : sum[26:0] << sh;
    en = sum[27] ? ex + 10'd1 : ex - sh;
    rnd = norm[2] & (norm[1] | norm[0] | norm[3]);
    m25 = {1'b0, norm[26:3]} + {24'b0, rnd};
    ef = m25[24] ? en + 10'd1 : (m25[23] ? en : 10'd0);
    if (x[30:23] == 8'hff)
      result = (x[22:0] != 23'd0 || (y[30:23] == 8'hff && x[31] != y[31])) ? 32'h7fc0_0000 : x;
    else if (sum == 28'd0)
      result = {x[31] & y[31], 31'd0};
    else if (ef >= 10'd255)
      result = {x[31], 8'hff, 23'd0};
    else
      result = {x[31], ef[7:0], m25[24] ? 23'd0 : m25[22:0]};
  end
endmodule

// File: rtl/fp_serial_alu.sv
// fp_serial_alu: beat-serial FP32 ADD/SUB/MIN/MAX; clk, rst, bus (slave: start/op, in_* beats, out_* beats, done/busy/state_out)
module fp_serial_alu #(parameter int BUS_W = 8) (
  input logic           clk,
  input logic           rst,
  fp_serial_alu_if.slave bus
);
  import fp_alu_pkg::*;
  localparam int BEATS = FP_W / BUS_W;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  state_e          state, nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_r;
  logic [FP_W-1:0] a, b, res, sum;
  logic            done_r, in_fire, out_fire, last;
  assign in_fire  = bus.in_valid & bus.in_ready;
  assign out_fire = bus.out_valid & bus.out_ready;
  assign last     = cnt == CW'(BEATS - 1);
  fp_addsub u_addsub (.a(a), .b(b), .sub(op_r == OP_SUB), .result(sum));
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_r   <= '0;
      a      <= '0;
      b      <= '0;
      res    <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= nxt;
      done_r <= out_fire & last;
      if (state == IDLE && bus.start) begin
        op_r <= bus.op;
        cnt  <= '0;
      end else if (in_fire || out_fire) begin
        cnt <= last ? '0 : cnt + CW'(1);
      end
      if (in_fire && state == LOAD_A) a[cnt*BUS_W +: BUS_W] <= bus.in_data;
      if (in_fire && state == LOAD_B) b[cnt*BUS_W +: BUS_W] <= bus.in_data;
      if (state == EXEC)
        res <= op_r == OP_MIN ? (key(b) < key(a) ? b : a) :
               op_r == OP_MAX ? (key(a) < key(b) ? b : a) : sum;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? LOAD_A : IDLE;
      LOAD_A:  nxt = in_fire && last ? LOAD_B : LOAD_A;
      LOAD_B:  nxt = in_fire && last ? EXEC : LOAD_B;
      EXEC:    nxt = OUT;
      OUT:     nxt = out_fire && last ? IDLE : OUT;
      default: nxt = IDLE;
    endcase
  end
  assign bus.in_ready  = state == LOAD_A || state == LOAD_B;
  assign bus.out_valid = state == OUT;
  assign bus.out_data  = bus.out_valid ? res[cnt*BUS_W +: BUS_W] : '0;
  assign bus.busy      = state != IDLE;
  assign bus.state_out = state;
  assign bus.done      = done_r;
endmodule

// File: tb/tb_fp_serial_alu.sv
// tb_fp_serial_alu: directed vector table plus stall, reset and bus-width sequences for fp_serial_alu
module tb_fp_serial_alu;
  import fp_alu_pkg::*;
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   passed = 0;
  vec_t vecs [14];
  always #5 clk = ~clk;
  fp_serial_alu_if #(.BUS_W(8))  v8 ();
  fp_serial_alu_if #(.BUS_W(16)) v16 ();
  fp_serial_alu_if #(.BUS_W(32)) v32 ();
  fp_serial_alu #(.BUS_W(8))  dut8  (.clk(clk), .rst(rst), .bus(v8.slave));
  fp_serial_alu #(.BUS_W(16)) dut16 (.clk(clk), .rst(rst), .bus(v16.slave));
  fp_serial_alu #(.BUS_W(32)) dut32 (.clk(clk), .rst(rst), .bus(v32.slave));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit gaps, input int stall_len, input string name);
    logic [31:0] r = '0;
    logic [7:0]  held = '0;
    int n = 0, ib = 0, ob = 0, sl = stall_len, extra = 0, lat = -1;
    v8.start = 1'b1;
    v8.op = o;
    @(posedge clk); #1;
    v8.start = 1'b0;
    v8.op = ~o;
    while (lat < 0 && n < 200) begin
      if (v8.done) lat = n + 1;
      else begin
        v8.start = gaps && v8.in_ready;
        v8.in_valid = ib < 8 && !(gaps && $urandom_range(0, 2) == 0);
        v8.in_data = ib < 4 ? a[ib*8 +: 8] : ib < 8 ? b[(ib-4)*8 +: 8] : 8'h00;
        v8.out_ready = !(v8.out_valid && ob == 1 && sl > 0);
        if (v8.in_ready) begin
          if (v8.in_valid) ib++;
          else extra++;
        end
        if (v8.out_valid && !v8.out_ready) begin
          if (sl == stall_len) held = v8.out_data;
          else chk({name, " stall_hold"}, 64'(v8.out_data), 64'(held));
          sl--;
          extra++;
        end else if (v8.out_valid) begin
          r[ob*8 +: 8] = v8.out_data;
          ob++;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    v8.start = 1'b0;
    v8.in_valid = 1'b0;
    v8.out_ready = 1'b1;
    chk({name, " result"}, 64'(r), 64'(exp));
    chk({name, " done_cycle"}, 64'(lat), 64'(14 + extra));
    chk({name, " idle_outputs"}, 64'({v8.busy, v8.out_valid, v8.in_ready, v8.out_data, v8.state_out}), 64'd0);
  endtask
  task automatic wdrive(input int w, input logic s, input logic [31:0] d);
    if (w == 16) begin
      v16.start = s;
      v16.in_data = d[15:0];
    end else begin
      v32.start = s;
      v32.in_data = d;
    end
  endtask
  task automatic run_wide(input int w);
    int bt = 32 / w;
    logic [31:0] r, a, b, exp;
    logic dn;
    for (int i = 0; i < 2; i++) begin
      a = i == 0 ? 32'h3F80_0000 : 32'h4040_0000;
      b = i == 0 ? 32'h4000_0000 : 32'h3F80_0000;
      exp = i == 0 ? 32'h4040_0000 : 32'h4080_0000;
      r = '0;
      wdrive(w, 1'b1, 32'h0);
      @(posedge clk); #1;
      for (int k = 0; k < 2 * bt; k++) begin
        wdrive(w, 1'b0, (k < bt ? a : b) >> ((k % bt) * w));
        @(posedge clk); #1;
      end
      @(posedge clk); #1;
      for (int k = 0; k < bt; k++) begin
        r = r | ((w == 16 ? {16'h0, v16.out_data} : v32.out_data) << (k * w));
        @(posedge clk); #1;
      end
      dn = w == 16 ? v16.done : v32.done;
      chk($sformatf("w%0d op%0d result", w, i), 64'(r), 64'(exp));
      chk($sformatf("w%0d op%0d done", w, i), 64'(dn), 64'd1);
    end
    wdrive(w, 1'b0, 32'h0);
  endtask
  initial begin
    vecs = '{
      '{OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000},
      '{OP_SUB, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000},
      '{OP_MAX, 32'hBF80_0000, 32'h3F00_0000, 32'h3F00_0000},
      '{OP_MIN, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000},
      '{OP_MIN, 32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000},
      '{OP_MAX, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000},
      '{OP_MAX, 32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000},
      '{OP_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000},
      '{OP_ADD, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000},
      '{OP_ADD, 32'h3FC0_0000, 32'h3FC0_0000, 32'h4040_0000},
      '{OP_SUB, 32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000},
      '{OP_MIN, 32'h7FC0_0000, 32'h3F80_0000, 32'h3F80_0000},
      '{OP_MAX, 32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000},
      '{OP_ADD, 32'h3DCC_CCCD, 32'h3E4C_CCCD, 32'h3E99_999A}
    };
    v8.start = 1'b0;
    v8.op = OP_ADD;
    v8.in_data = 8'h00;
    v8.in_valid = 1'b0;
    v8.out_ready = 1'b1;
    v16.start = 1'b0;
    v16.op = OP_ADD;
    v16.in_data = 16'h0;
    v16.in_valid = 1'b1;
    v16.out_ready = 1'b1;
    v32.start = 1'b0;
    v32.op = OP_ADD;
    v32.in_data = 32'h0;
    v32.in_valid = 1'b1;
    v32.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({v8.in_ready, v8.out_valid, v8.out_data, v8.busy, v8.state_out, v8.done}), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 14; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, 0, $sformatf("vec%0d", i));
    run_op(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1, 3, "stall");
    v8.start = 1'b1;
    v8.op = OP_ADD;
    @(posedge clk); #1;
    v8.start = 1'b0;
    v8.in_valid = 1'b1;
    v8.in_data = 8'hA5;
    repeat (6) begin
      @(posedge clk); #1;
    end
    chk("pre_reset_state", 64'(v8.state_out), 64'(LOAD_B));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    v8.in_valid = 1'b0;
    chk("mid_reset_outputs", 64'({v8.in_ready, v8.out_valid, v8.out_data, v8.busy, v8.state_out, v8.done}), 64'd0);
    run_op(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 0, "after_reset");
    run_wide(16);
    run_wide(32);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
